// File: rtl/mod_counter_ctrl_pkg.sv
// Shared definitions for the modulo-N counter controller and its users:
// FSM state encodings and default datapath widths.
package mod_counter_ctrl_pkg;

  // Default counter width; with limit = 15 this gives a mod-16 counter.
  localparam int DEF_WIDTH    = 4;
  // Default width of the period-count field.
  localparam int DEF_REPEAT_W = 4;

  // Controller states. The encoding is fixed so external checkers and
  // other counter users can decode the debug state output directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter datapath: counts 0..limit and wraps to 0.
// It has no notion of runs or periods; the controller gates it with en/clr.
module mod_n_counter
  import mod_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Wrap is the cycle in which an enabled counter sits on its terminal value.
  assign wrap  = en && (count_q == limit);
  assign count = count_q;

  // Next count: clear wins, otherwise advance or wrap while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (wrap) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Sequencing controller for the modulo-N counter. Accepts a one-cycle
// command (limit, repeat), runs the counter through that many periods,
// pulses tick per period and done at the end. pause freezes, stop aborts.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high only in IDLE;
// cmd_valid seen while cmd_ready is low is dropped, never queued.
module mod_counter_ctrl
  import mod_counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REPEAT_W = DEF_REPEAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_limit,
  input  logic [REPEAT_W-1:0] cmd_repeat,
  input  logic                pause,
  input  logic                stop,
  output logic [WIDTH-1:0]    count,
  output logic                tick,
  output logic                done,
  output logic                busy,
  output state_e              dbg_state
);

  state_e              state_q;
  state_e              state_d;
  logic [WIDTH-1:0]    limit_q;
  logic [WIDTH-1:0]    limit_d;
  logic [REPEAT_W-1:0] repeat_q;
  logic [REPEAT_W-1:0] repeat_d;
  logic [REPEAT_W-1:0] elapsed_q;
  logic [REPEAT_W-1:0] elapsed_d;
  logic [REPEAT_W-1:0] elapsed_inc;

  logic cnt_en;
  logic cnt_clr;
  logic cnt_wrap;

  // The counter only moves in an unpaused, unstopped RUN; anywhere else it
  // is held at 0 so a freshly accepted command always starts from 0.
  assign cnt_en  = (state_q == ST_RUN) && !pause && !stop;
  assign cnt_clr = stop || (state_q != ST_RUN);

  mod_n_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (limit_q),
    .count (count),
    .wrap  (cnt_wrap)
  );

  // Status outputs decode straight from registers plus the counter wrap.
  assign tick      = cnt_wrap;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign cmd_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // Next-state, config latch and period bookkeeping.
  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    repeat_d    = repeat_q;
    elapsed_d   = elapsed_q;
    elapsed_inc = elapsed_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        // stop and pause have no meaning here; only a command moves us.
        if (cmd_valid && cmd_ready) begin
          limit_d   = cmd_limit;
          repeat_d  = cmd_repeat;
          elapsed_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (!pause && cnt_wrap) begin
          // repeat == 0 means run forever; elapsed then wraps silently.
          elapsed_d = elapsed_inc;
          if ((repeat_q != '0) && (elapsed_inc == repeat_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, config and period registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      repeat_q  <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      repeat_q  <= repeat_d;
      elapsed_q <= elapsed_d;
    end
  end

endmodule
